// File: rtl/full_adder_reg.sv
// full_adder_reg: registered ripple-carry adder built from 1-bit full-adder
// cells. {cout, sum} = a + b + cin, captured one cycle after in_valid.
// Optional macro FULL_ADDER_REG_OVF_EN adds a registered two's-complement
// overflow flag (ovf = c_WIDTH ^ c_(WIDTH-1)).
module full_adder_reg #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             out_valid
`ifdef FULL_ADDER_REG_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_raw;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  // Ripple carry chain: one full-adder cell per bit, carry[0] = cin.
  always_comb begin
    carry    = '0;
    sum_raw  = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_raw[i]   = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  // Next-state: capture on in_valid, otherwise hold data; valid follows in_valid.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = sum_raw;
      cout_d      = carry[WIDTH];
      out_valid_d = 1'b1;
    end
  end

  // Output register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

`ifdef FULL_ADDER_REG_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow next-state: carry into vs. out of the MSB cell, held when idle.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  // Overflow flag register, reset alongside the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// Bench for full_adder_reg: four instances (WIDTH = 1, 4, 8, 64) share clk
// and rst_n. A behavioural model computes a + b + cin with wide arithmetic
// and keeps the expected registered result; directed vectors plus random
// traffic exercise every instance each cycle.
module tb_full_adder_reg;

  localparam int NDUT = 4;
  localparam int unsigned W_TAB [NDUT] = '{1, 4, 8, 64};

  logic clk = 1'b0;
  logic rst_n;

  logic [63:0] a_v [NDUT];
  logic [63:0] b_v [NDUT];
  logic        cin_v [NDUT];
  logic        iv_v [NDUT];

  logic [0:0]  s0;
  logic [3:0]  s1;
  logic [7:0]  s2;
  logic [63:0] s3;
  logic        co [NDUT];
  logic        ov [NDUT];
  logic        of [NDUT];

  logic [63:0] exp_sum [NDUT];
  logic        exp_cout [NDUT];
  logic        exp_vld [NDUT];
  logic        exp_ovf [NDUT];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  full_adder_reg #(.WIDTH(1)) u_w1 (
    .sum(s0), .cout(co[0]), .a(a_v[0][0:0]), .b(b_v[0][0:0]), .cin(cin_v[0]),
    .clk(clk), .rst_n(rst_n), .in_valid(iv_v[0]), .out_valid(ov[0])
`ifdef FULL_ADDER_REG_OVF_EN
    , .ovf(of[0])
`endif
  );
  full_adder_reg #(.WIDTH(4)) u_w4 (
    .sum(s1), .cout(co[1]), .a(a_v[1][3:0]), .b(b_v[1][3:0]), .cin(cin_v[1]),
    .clk(clk), .rst_n(rst_n), .in_valid(iv_v[1]), .out_valid(ov[1])
`ifdef FULL_ADDER_REG_OVF_EN
    , .ovf(of[1])
`endif
  );
  full_adder_reg #(.WIDTH(8)) u_w8 (
    .sum(s2), .cout(co[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]),
    .clk(clk), .rst_n(rst_n), .in_valid(iv_v[2]), .out_valid(ov[2])
`ifdef FULL_ADDER_REG_OVF_EN
    , .ovf(of[2])
`endif
  );
  full_adder_reg #(.WIDTH(64)) u_w64 (
    .sum(s3), .cout(co[3]), .a(a_v[3]), .b(b_v[3]), .cin(cin_v[3]),
    .clk(clk), .rst_n(rst_n), .in_valid(iv_v[3]), .out_valid(ov[3])
`ifdef FULL_ADDER_REG_OVF_EN
    , .ovf(of[3])
`endif
  );

`ifndef FULL_ADDER_REG_OVF_EN
  initial for (int k = 0; k < NDUT; k++) of[k] = 1'b0;
`endif

  function automatic logic [63:0] mask(int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] got_sum(int k);
    case (k)
      0: return {63'd0, s0};
      1: return {60'd0, s1};
      2: return {56'd0, s2};
      default: return s3;
    endcase
  endfunction

  // Signed overflow: true result of signed(a) + signed(b) + cin leaves the
  // w-bit two's-complement range.
  function automatic logic ref_ovf(int unsigned w, logic [63:0] a, logic [63:0] b, logic cin);
    logic signed [66:0] sa, sb, s, hi, lo, one;
    one = 67'sd1;
    sa = $signed({3'b000, a & mask(w)});
    sb = $signed({3'b000, b & mask(w)});
    if (a[w-1]) sa = sa - (one <<< w);
    if (b[w-1]) sb = sb - (one <<< w);
    s  = sa + sb + $signed({66'd0, cin});
    hi = (one <<< (w - 1)) - one;
    lo = -(one <<< (w - 1));
    return (s > hi) || (s < lo);
  endfunction

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("%s_sum_w%0d", tag, W_TAB[k]), {1'b0, got_sum(k)}, {1'b0, exp_sum[k]});
      check_eq($sformatf("%s_cout_w%0d", tag, W_TAB[k]), {64'd0, co[k]}, {64'd0, exp_cout[k]});
      check_eq($sformatf("%s_vld_w%0d", tag, W_TAB[k]), {64'd0, ov[k]}, {64'd0, exp_vld[k]});
`ifdef FULL_ADDER_REG_OVF_EN
      check_eq($sformatf("%s_ovf_w%0d", tag, W_TAB[k]), {64'd0, of[k]}, {64'd0, exp_ovf[k]});
`endif
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      exp_sum[k] = '0; exp_cout[k] = 1'b0; exp_vld[k] = 1'b0; exp_ovf[k] = 1'b0;
    end
  endtask

  // One clock: model samples inputs at the edge, outputs compared 1 ns later.
  task automatic tick(input string tag);
    logic [64:0] full;
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) continue;
      exp_vld[k] = iv_v[k];
      if (iv_v[k]) begin
        full = {1'b0, a_v[k] & mask(W_TAB[k])} + {1'b0, b_v[k] & mask(W_TAB[k])}
             + {64'd0, cin_v[k]};
        exp_sum[k]  = full[63:0] & mask(W_TAB[k]);
        exp_cout[k] = full[W_TAB[k]];
        exp_ovf[k]  = ref_ovf(W_TAB[k], a_v[k], b_v[k], cin_v[k]);
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic rand_all();
    for (int k = 0; k < NDUT; k++) begin
      a_v[k]   = {$urandom, $urandom};
      b_v[k]   = {$urandom, $urandom};
      cin_v[k] = 1'($urandom_range(0, 1));
      iv_v[k]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic set_op(input int k, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic iv);
    a_v[k] = a; b_v[k] = b; cin_v[k] = cin; iv_v[k] = iv;
  endtask

  logic [1:0] w1_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    for (int k = 0; k < NDUT; k++) set_op(k, '0, '0, 1'b0, 1'b0);
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all("reset");
    rand_all();
    tick("in_reset");
    tick("in_reset2");
    rst_n = 1'b1;

    // WIDTH=1 exhaustive truth table.
    for (int i = 0; i < 8; i++) begin
      rand_all();
      set_op(0, {63'd0, 1'(i >> 2)}, {63'd0, 1'(i >> 1)}, 1'(i), 1'b1);
      tick("w1_exh");
      check_eq($sformatf("w1_tab%0d", i), {63'd0, co[0], s0}, {63'd0, w1_tab[i]});
    end

    // WIDTH=8 carry boundaries.
    rand_all();
    set_op(2, 64'hFF, 64'h01, 1'b0, 1'b1);
    tick("w8_ff01");
    check_eq("w8_ff01_k", {56'd0, co[2], s2}, {56'd0, 9'h100});
    rand_all();
    set_op(2, 64'hFF, 64'hFF, 1'b1, 1'b1);
    tick("w8_ffff1");
    check_eq("w8_ffff1_k", {56'd0, co[2], s2}, {56'd0, 9'h1FF});

    // Asynchronous reset mid-cycle while sum = 0xFF, then first op after release.
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    check_eq("async_rst_w8", {56'd0, co[2], s2}, 65'd0);
    rand_all();
    tick("rst_hold");
    rst_n = 1'b1;
    rand_all();
    set_op(2, 64'h3C, 64'h42, 1'b1, 1'b1);
    tick("w8_3c42");
    check_eq("w8_3c42_k", {56'd0, co[2], s2}, {56'd0, 9'h07F});
    check_eq("w8_3c42_vld", {64'd0, ov[2]}, 65'd1);

    // WIDTH=4 hold with in_valid low, including X operands.
    rand_all();
    set_op(1, 64'd5, 64'd3, 1'b0, 1'b1);
    tick("w4_op");
    rand_all();
    set_op(1, 64'hF, 64'hF, 1'b1, 1'b0);
    tick("w4_hold");
    check_eq("w4_hold_k", {59'd0, ov[1], co[1], s1}, {59'd0, 6'b0_0_1000});
    rand_all();
    set_op(1, 'x, 'x, 1'bx, 1'b0);
    tick("w4_hold_x");
    check_eq("w4_hold_x_k", {60'd0, co[1], s1}, {60'd0, 5'b0_1000});

    // Signed-overflow vectors at WIDTH=8 (ovf compared when the flag exists).
    rand_all();
    set_op(2, 64'h7F, 64'h01, 1'b0, 1'b1);
    tick("w8_ovf1");
    rand_all();
    set_op(2, 64'h80, 64'h80, 1'b0, 1'b1);
    tick("w8_ovf2");
    rand_all();
    set_op(2, 64'h10, 64'h20, 1'b0, 1'b1);
    tick("w8_ovf3");

    // Random traffic on every width.
    for (int n = 0; n < 10000; n++) begin
      rand_all();
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
- Registered, parameterizable ripple-carry full adder: a chain of 1-bit full-adder cells, result captured in an output register.
- Default WIDTH=1 is the classic single-bit full adder (sum, cout from a, b, cin) with one cycle of latency.
- Used as a leaf arithmetic primitive in datapaths and as the reference cell for adder-tree blocks.
- Valid strobe travels alongside the data.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sum  output  WIDTH  registered sum bits, (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of MSB position.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry in to bit 0.
- in_valid  input  1  qualifies a, b, cin this cycle.
- out_valid  output  1  qualifies sum, cout.

Interface note: one clock (clk); reset rst_n is asynchronous and active-low. Data port order at instantiation is sum, cout, a, b, cin, followed by the control ports.

Behaviour:
- Cell i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (a_i & c_i) | (b_i & c_i); c_0 = cin; cout = c_WIDTH.
- Full result {cout, sum} = a + b + cin, exact over WIDTH+1 bits; no saturation, no wrap loss.
- Carry chain is purely combinational from inputs to the output register.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on sum/cout/out_valid after edge N.
- in_valid=1 at an edge: register the new sum and cout; out_valid <= 1.
- in_valid=0 at an edge: sum and cout hold their previous values; out_valid <= 0.
- Throughput: one operation per cycle. No backpressure and no ready signal; a new operation can be accepted every cycle.
- Reset (rst_n=0, asynchronous): sum=0, cout=0, out_valid=0 immediately, independent of clk.
- While rst_n=0, inputs are ignored.
- First valid capture occurs at the first rising edge after rst_n deasserts with in_valid=1.
- Reset mid-operation: an in-flight result is discarded; out_valid drops with no glitch to 1.
- Boundary: all-ones + all-ones + 1 gives sum = all-ones, cout=1. Zero + zero + 0 gives sum=0, cout=0.
- X on inputs while in_valid=0 must not propagate into the registers.

Optional Feature:
- Macro: FULL_ADDER_REG_OVF_EN.
- Defined: adds output ovf (1 bit), registered with sum.
- ovf = c_WIDTH ^ c_(WIDTH-1), i.e. two's-complement signed overflow. For WIDTH=1, c_0 = cin.
- ovf resets to 0 and holds when in_valid=0.
- Not defined: port ovf is absent and no logic is generated; all other behaviour is identical.

Test Plan:
- WIDTH=1, exhaustive: apply (a,b,cin) = 000, 001, 010, 011, 100, 101, 110, 111 with in_valid=1, one per cycle -> one cycle later (sum,cout) = 00, 10, 10, 01, 10, 01, 01, 11; out_valid=1 throughout.
- WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Next: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Next: a=0x3C, b=0x42, cin=1 -> sum=0x7F, cout=0.
- Hold: valid op a=5, b=3, cin=0 (WIDTH=4) gives sum=8, cout=0; then in_valid=0 with a=F, b=F -> sum stays 8, cout stays 0, out_valid=0.
- Async reset: assert rst_n=0 mid-cycle while sum=0xFF -> sum=0, cout=0, out_valid=0 before the next clk edge. Release rst_n; first valid op captured on the following edge.
- FULL_ADDER_REG_OVF_EN defined, WIDTH=8: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1. Then a=0x10, b=0x20 -> ovf=0.
- Random: 10k random a, b, cin with random in_valid at WIDTH=1, 8, 64 -> {cout,sum} equals the reference model of a+b+cin, delayed one cycle.
